// File: rtl/seg7_scan_display.sv
// seg7_scan_display
//   Time-multiplexed 4-digit 7-segment scanner for the CPU R15 output value.
//   The value is shown either as two hex digits or as up to three unsigned
//   decimal digits with leading-zero blanking. A sequential double-dabble
//   converter (IDLE -> LOAD -> SHIFT x8 -> DONE) produces the BCD digits.
//   The display registers change only in DONE, so a partial conversion is
//   never shown. Runs entirely on the undivided board clock.
//
// Parameters
//   REFRESH_DIV : clk cycles per digit slot (>= 2)
//   BLINK_TICKS : digit-slot advances per blink half-period (HALT_BLINK_EN only)
//
// Ports
//   clk      in   board clock
//   rst      in   synchronous, active-high reset
//   value    in   [7:0] value to display
//   dec_mode in   0 = hex (2 digits), 1 = unsigned decimal (3 digits)
//   halt     in   CPU halt flag (used only when HALT_BLINK_EN is defined)
//   seg      out  [6:0] segment cathodes, active-low, seg[0]=a .. seg[6]=g
//   an       out  [3:0] digit anodes, active-low, an[0] = rightmost digit
//
// Optional feature
//   `define HALT_BLINK_EN : while halt=1, blank the whole display on
//   alternate blink half-periods.

module seg7_scan_display #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLINK_TICKS = 256
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] value,
    input  logic       dec_mode,
    input  logic       halt,
    output logic [6:0] seg,
    output logic [3:0] an
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Scan timing
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] refresh_cnt_q, refresh_cnt_d;
    logic [1:0]       digit_sel_q, digit_sel_d;
    logic             advance;

    always_comb begin
        advance       = (refresh_cnt_q == CNT_W'(REFRESH_DIV - 1));
        refresh_cnt_d = advance ? '0 : refresh_cnt_q + CNT_W'(1);
        digit_sel_d   = advance ? digit_sel_q + 2'd1 : digit_sel_q;
    end

    // ------------------------------------------------------------------
    // Double-dabble converter
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [7:0]  captured_q, captured_d;
    logic [19:0] shift_q, shift_d;   // {hundreds, tens, ones, binary}
    logic [2:0]  iter_q, iter_d;
    logic [3:0]  ones_q, ones_d;
    logic [3:0]  tens_q, tens_d;
    logic [3:0]  hund_q, hund_d;
    logic [7:0]  hex_q, hex_d;
    logic [19:0] adj;

    function automatic logic [3:0] dab(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    always_comb begin
        state_d    = state_q;
        captured_d = captured_q;
        shift_d    = shift_q;
        iter_d     = iter_q;
        ones_d     = ones_q;
        tens_d     = tens_q;
        hund_d     = hund_q;
        hex_d      = hex_q;
        adj        = shift_q;
        unique case (state_q)
            IDLE: begin
                if (value != captured_q) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                captured_d = value;
                shift_d    = {12'b0, value};
                iter_d     = '0;
                state_d    = SHIFT;
            end
            SHIFT: begin
                adj[19:16] = dab(shift_q[19:16]);
                adj[15:12] = dab(shift_q[15:12]);
                adj[11:8]  = dab(shift_q[11:8]);
                shift_d    = {adj[18:0], 1'b0};
                iter_d     = iter_q + 3'd1;
                if (iter_q == 3'd7) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // All display registers change together here, and only here.
                ones_d  = shift_q[11:8];
                tens_d  = shift_q[15:12];
                hund_d  = shift_q[19:16];
                hex_d   = captured_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Halt blink
    // ------------------------------------------------------------------
    logic force_blank;

`ifdef HALT_BLINK_EN
    localparam int unsigned BW = $clog2(BLINK_TICKS + 1);

    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_phase_q, blink_phase_d;

    always_comb begin
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (advance) begin
            if (blink_cnt_q == BW'(BLINK_TICKS - 1)) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BW'(1);
            end
        end
        force_blank = halt & blink_phase_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
        end else begin
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end
`else
    logic unused_cfg;

    assign force_blank = 1'b0;
    assign unused_cfg  = halt ^ (BLINK_TICKS == 32'd0);
`endif

    // ------------------------------------------------------------------
    // Slot decode and registered outputs
    // ------------------------------------------------------------------
    logic [6:0] seg_q, seg_d;
    logic [3:0] an_q, an_d;
    logic [3:0] nib;
    logic       blank;

    function automatic logic [6:0] font(input logic [3:0] d);
        logic [6:0] f;
        unique case (d)
            4'h0: f = 7'b1000000;
            4'h1: f = 7'b1111001;
            4'h2: f = 7'b0100100;
            4'h3: f = 7'b0110000;
            4'h4: f = 7'b0011001;
            4'h5: f = 7'b0010010;
            4'h6: f = 7'b0000010;
            4'h7: f = 7'b1111000;
            4'h8: f = 7'b0000000;
            4'h9: f = 7'b0010000;
            4'hA: f = 7'b0001000;
            4'hB: f = 7'b0000011;
            4'hC: f = 7'b1000110;
            4'hD: f = 7'b0100001;
            4'hE: f = 7'b0000110;
            default: f = 7'b0001110;
        endcase
        return f;
    endfunction

    always_comb begin
        nib   = '0;
        blank = 1'b1;
        unique case (digit_sel_q)
            2'd0: begin
                nib   = dec_mode ? ones_q : hex_q[3:0];
                blank = 1'b0;
            end
            2'd1: begin
                nib   = dec_mode ? tens_q : hex_q[7:4];
                blank = dec_mode && (hund_q == 4'd0) && (tens_q == 4'd0);
            end
            2'd2: begin
                nib   = hund_q;
                blank = !dec_mode || (hund_q == 4'd0);
            end
            default: begin
                nib   = '0;
                blank = 1'b1;
            end
        endcase
        if (force_blank) begin
            blank = 1'b1;
        end
        seg_d = blank ? '1 : font(nib);
        an_d  = blank ? '1 : ~(4'b0001 << digit_sel_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_cnt_q <= '0;
            digit_sel_q   <= '0;
            state_q       <= IDLE;
            captured_q    <= '0;
            shift_q       <= '0;
            iter_q        <= '0;
            ones_q        <= '0;
            tens_q        <= '0;
            hund_q        <= '0;
            hex_q         <= '0;
            seg_q         <= '1;
            an_q          <= '1;
        end else begin
            refresh_cnt_q <= refresh_cnt_d;
            digit_sel_q   <= digit_sel_d;
            state_q       <= state_d;
            captured_q    <= captured_d;
            shift_q       <= shift_d;
            iter_q        <= iter_d;
            ones_q        <= ones_d;
            tens_q        <= tens_d;
            hund_q        <= hund_d;
            hex_q         <= hex_d;
            seg_q         <= seg_d;
            an_q          <= an_d;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;

endmodule
